// File: rtl/sipo_pkg.sv
// sipo_pkg: definitions shared by the serial-in/parallel-out receiver files.
//   SIPO_WIDTH   : default number of data bits per frame
//   sipo_state_e : receiver FSM states
package sipo_pkg;

    localparam int SIPO_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        FULL   = 2'd3
    } sipo_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: WIDTH-bit shift register with clear, enable and direction.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : zero the register (wins over en_i)
//   en_i           : shift bit_i in this cycle
//   msb_first_i    : 1 = shift left (first bit ends in MSB), 0 = shift right
//   bit_i          : serial data bit
//   next_o         : value the register takes at the coming edge
import sipo_pkg::*;

module sipo_shift_reg #(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             msb_first_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (clear_i) begin
            sreg_d = '0;
        end else if (en_i) begin
            if (msb_first_i) begin
                sreg_d = {sreg_q[WIDTH-2:0], bit_i};
            end else begin
                sreg_d = {bit_i, sreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Exposing the next value lets the receiver capture the completed word
    // on the same edge that samples the final bit.
    assign next_o = sreg_d;

endmodule

// File: rtl/sipo_receiver.sv
// sipo_receiver: rebuilds a WIDTH-bit word from a qualified serial stream and
// presents it on a valid/ready handshake.
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   start_i         : begin a frame (IDLE only)
//   msb_first_i     : bit order, latched with start
//   serial_i        : serial data bit, qualified by serial_valid_i
//   data_out_o      : last completed word
//   data_valid_o    : data_out_o holds an unconsumed frame
//   data_ready_i    : consumer takes the word
//   busy_o          : receiver is not IDLE
//   overrun_o       : sticky, a bit arrived in IDLE or FULL
//   parity_err_o    : even-parity failure, qualified by data_valid_o
// Optional feature: define PARITY_RX_EN to receive and check a trailing
// even-parity bit; otherwise parity_err_o is constant 0.
import sipo_pkg::*;

module sipo_receiver #(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             msb_first_i,
    input  logic             serial_i,
    input  logic             serial_valid_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sipo_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic             msb_first_q;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             busy_q;
    logic             overrun_q;
    logic [WIDTH-1:0] sreg_next;
    logic             sreg_clear;
    logic             sreg_en;

    assign sreg_clear = (state_q == IDLE) && start_i;
    assign sreg_en    = (state_q == SHIFT) && serial_valid_i;

    sipo_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (sreg_clear),
        .en_i        (sreg_en),
        .msb_first_i (msb_first_q),
        .bit_i       (serial_i),
        .next_o      (sreg_next)
    );

`ifdef PARITY_RX_EN
    logic parity_q;
    logic parity_err_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            msb_first_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_RX_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (serial_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (start_i) begin
                        state_q     <= SHIFT;
                        busy_q      <= 1'b1;
                        count_q     <= '0;
                        msb_first_q <= msb_first_i;
                        // A bit dropped on the start cycle still counts as overrun.
                        overrun_q   <= serial_valid_i;
`ifdef PARITY_RX_EN
                        parity_q    <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (serial_valid_i) begin
                        count_q <= count_q + CNT_W'(1);
`ifdef PARITY_RX_EN
                        parity_q <= parity_q ^ serial_i;
`endif
                        if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_RX_EN
                            state_q      <= PARITY;
`else
                            state_q      <= FULL;
                            data_valid_q <= 1'b1;
                            data_out_q   <= sreg_next;
`endif
                        end
                    end
                end
`ifdef PARITY_RX_EN
                PARITY: begin
                    if (serial_valid_i) begin
                        // Register is idle here, so sreg_next is the finished word.
                        parity_err_q <= parity_q ^ serial_i;
                        state_q      <= FULL;
                        data_valid_q <= 1'b1;
                        data_out_q   <= sreg_next;
                    end
                end
`endif
                FULL: begin
                    if (serial_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (data_valid_q && data_ready_i) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        data_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
`ifdef PARITY_RX_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed self-checking bench for sipo_receiver (WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Bit sequences are written with the first transmitted bit in position [7].
`timescale 1ns/1ps

module tb_sipo_receiver;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       msb_first_i = 1'b0;
    logic       serial_i = 1'b0;
    logic       serial_valid_i = 1'b0;
    logic [7:0] data_out_o;
    logic       data_valid_o;
    logic       data_ready_i = 1'b0;
    logic       busy_o;
    logic       overrun_o;
    logic       parity_err_o;

    int total = 0;
    int bad = 0;

    sipo_receiver #(.WIDTH(8)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .msb_first_i    (msb_first_i),
        .serial_i       (serial_i),
        .serial_valid_i (serial_valid_i),
        .data_out_o     (data_out_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .parity_err_o   (parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic begin_frame(input logic msb);
        start_i     = 1'b1;
        msb_first_i = msb;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        serial_i       = b;
        serial_valid_i = 1'b1;
        tick();
        serial_valid_i = 1'b0;
    endtask

    // Sends seq bits with positions first..last (0 = first transmitted bit).
    task automatic send_bits(input logic [7:0] seq, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_bit(seq[7-i]);
        end
    endtask

    // Parity bit only exists when the receiver expects it.
    task automatic send_parity(input logic p);
`ifdef PARITY_RX_EN
        send_bit(p);
`endif
    endtask

    task automatic drain();
        data_ready_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        total++; if (data_out_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out_o); end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity_err_o); end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_lsb_first();
        begin_frame(1'b0);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL lsb_busy got=%b exp=1", busy_o); end
        send_bits(8'b1111_0000, 0, 6);
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL lsb_early_valid got=%b exp=0", data_valid_o); end
        send_bits(8'b1111_0000, 7, 7);
`ifdef PARITY_RX_EN
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL lsb_valid_before_parity got=%b exp=0", data_valid_o); end
`endif
        send_parity(1'b0);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b exp=1", data_valid_o); end
        total++; if (data_out_o !== 8'h0F) begin bad++; $display("FAIL lsb_data got=%h exp=0f", data_out_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL lsb_overrun got=%b exp=0", overrun_o); end
        drain();
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL lsb_valid_drop got=%b exp=0", data_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lsb_idle got=%b exp=0", busy_o); end
        total++; if (data_out_o !== 8'h0F) begin bad++; $display("FAIL lsb_data_hold got=%h exp=0f", data_out_o); end
    endtask

    task automatic test_msb_first();
        begin_frame(1'b1);
        send_bits(8'b1111_0000, 0, 7);
        send_parity(1'b0);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b exp=1", data_valid_o); end
        total++; if (data_out_o !== 8'hF0) begin bad++; $display("FAIL msb_data got=%h exp=f0", data_out_o); end
        drain();
    endtask

    task automatic test_backpressure();
        begin_frame(1'b1);
        send_bits(8'b1100_1010, 0, 7);
        send_parity(1'b0);
        total++; if (data_out_o !== 8'hCA) begin bad++; $display("FAIL bp_data got=%h exp=ca", data_out_o); end
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0]);
            total++; if (data_out_o !== 8'hCA) begin bad++; $display("FAIL bp_stable[%0d] got=%h exp=ca", i, data_out_o); end
            total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, data_valid_o); end
        end
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b exp=1", overrun_o); end
        drain();
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky got=%b exp=1", overrun_o); end
        begin_frame(1'b1);
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL bp_overrun_clear got=%b exp=0", overrun_o); end
        send_bits(8'b0011_1100, 0, 7);
        send_parity(1'b0);
        total++; if (data_out_o !== 8'h3C) begin bad++; $display("FAIL bp_next_data got=%h exp=3c", data_out_o); end
        drain();
    endtask

    task automatic test_reset_midframe();
        begin_frame(1'b0);
        send_bits(8'b1010_0101, 0, 2);
        #2;
        reset_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy_o); end
        total++; if (data_out_o !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", data_out_o); end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", data_valid_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL mid_overrun got=%b exp=0", overrun_o); end
        tick();
        reset_i = 1'b0;
        tick();
        begin_frame(1'b0);
        send_bits(8'b1010_0101, 0, 7);
        send_parity(1'b0);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL mid_new_valid got=%b exp=1", data_valid_o); end
        total++; if (data_out_o !== 8'hA5) begin bad++; $display("FAIL mid_new_data got=%h exp=a5", data_out_o); end
        drain();
    endtask

    task automatic test_start_ignored();
        begin_frame(1'b0);
        send_bits(8'b0011_0110, 0, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy_o); end
        send_bits(8'b0011_0110, 3, 7);
        send_parity(1'b0);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL ign_valid got=%b exp=1", data_valid_o); end
        total++; if (data_out_o !== 8'h6C) begin bad++; $display("FAIL ign_data got=%h exp=6c", data_out_o); end
        start_i      = 1'b1;
        data_ready_i = 1'b1;
        tick();
        start_i      = 1'b0;
        data_ready_i = 1'b0;
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL ign_full_valid got=%b exp=0", data_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_full_busy got=%b exp=0", busy_o); end
        tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_stays_idle got=%b exp=0", busy_o); end
    endtask

`ifdef PARITY_RX_EN
    task automatic test_parity();
        begin_frame(1'b0);
        send_bits(8'b1111_0000, 0, 7);
        send_bit(1'b0);
        total++; if (data_out_o !== 8'h0F) begin bad++; $display("FAIL par_ok_data got=%h exp=0f", data_out_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL par_ok_err got=%b exp=0", parity_err_o); end
        drain();
        begin_frame(1'b0);
        send_bits(8'b1111_0000, 0, 7);
        send_bit(1'b1);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL par_bad_valid got=%b exp=1", data_valid_o); end
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b exp=1", parity_err_o); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_reset_midframe();
        test_start_ignored();
`ifdef PARITY_RX_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in/parallel-out frame receiver. It rebuilds a WIDTH-bit word from a bit-serial stream produced by the team's rotate/shift-register transmitters. Bits are accepted one per qualified clock. The completed word is presented on a valid/ready output handshake. It sits between a shift-out source and any parallel consumer, such as the LEDR display or a downstream register.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
- start  input  1  begin a frame; honoured only in IDLE
- msb_first  input  1  bit order; sampled when start is accepted
- serial_in  input  1  serial data bit
- serial_valid  input  1  serial_in qualifier; one bit per high cycle
- data_out  output  WIDTH  assembled word
- data_valid  output  1  data_out holds a complete frame
- data_ready  input  1  consumer accepts the word
- busy  output  1  high in any state other than IDLE
- overrun  output  1  sticky; a bit arrived while it could not be accepted
- parity_err  output  1  parity check result, qualified by data_valid

## Operation
- States: IDLE, SHIFT, PARITY (only with the macro), FULL.
- **IDLE**
  - When start=1: clear the shift register and the bit count, latch msb_first, clear overrun, go to SHIFT.
- **SHIFT**, on each serial_valid=1:
  - msb_first=1: sreg <= {sreg[WIDTH-2:0], serial_in}. The first bit ends up in the MSB.
  - msb_first=0: sreg <= {serial_in, sreg[WIDTH-1:1]}. The first bit ends up in the LSB; this mirrors a rotate-right transmitter.
  - Increment count. On the bit with count==WIDTH-1, go to FULL, or to PARITY when the macro is enabled.
  - serial_valid=0 holds all state. There is no timeout.
- **FULL**
  - data_out = sreg and data_valid=1.
  - On data_valid & data_ready, go to IDLE. data_valid drops in that cycle's successor.
  - data_out keeps the last word until the next frame completes.
- serial_valid=1 in IDLE or FULL: the bit is dropped and overrun is set. overrun stays set until reset or an accepted start.
- start while not in IDLE is ignored. start and data_ready high together in FULL: the transfer completes and start is ignored.
- Count width is clog2(WIDTH+1). The count never exceeds WIDTH.

## Timing
- Reset values:
  - data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0.
  - state=IDLE, count=0.
- start accepted at edge N: busy=1 from N. The first bit can be sampled at edge N+1.
- Final data bit sampled at edge M: data_valid=1 after M. With PARITY, data_valid=1 after the parity bit's edge.
- Back-to-back serial_valid: data_valid rises WIDTH cycles after the first sampled bit, or WIDTH+1 with parity.
- Handshake completes at the edge where data_valid & data_ready. The minimum frame turnaround is one IDLE cycle.
- Reset mid-frame: the partial word is discarded and the state machine returns to IDLE asynchronously.

## Configuration
- PARITY_RX_EN defined:
  - After WIDTH data bits, one more serial_valid bit is taken as the parity bit. The PARITY state consumes it.
  - Even parity applies: parity_err = XOR of all WIDTH+1 bits, registered when entering FULL and held with data_valid.
  - An overrun in the PARITY state follows the SHIFT rules.
- PARITY_RX_EN undefined:
  - No PARITY state exists.
  - parity_err is tied to 0.

## Structure
- Shared package sipo_pkg:
  - state enum {IDLE, SHIFT, PARITY, FULL}
  - default width constant SIPO_WIDTH=8
- Sub-module sipo_shift_reg:
  - WIDTH-bit register with clear, enable and direction select.
  - The FSM, counter and handshake stay in sipo_receiver.

## Test plan
- LSB-first frame: start, msb_first=0, bits 1,1,1,1,0,0,0,0 -> data_out=0x0F, data_valid=1 after the 8th bit.
- MSB-first frame: same bit sequence with msb_first=1 -> data_out=0xF0.
- Backpressure: hold data_ready=0 for 5 cycles after a frame with extra serial_valid pulses -> data_out stable, overrun=1; the next start clears overrun.
- Reset after 3 bits -> all outputs 0, busy=0. A new frame of 0xA5 then receives correctly.
- Start while busy, plus start together with data_ready in FULL -> both ignored; one word is delivered and the FSM returns to IDLE.
- PARITY_RX_EN: 0x0F then parity bit 0 -> parity_err=0. 0x0F then parity bit 1 -> parity_err=1.
